// File: rtl/mux_input_conditioner_pkg.sv
// Shared constants and helpers for the mux input conditioner.
//
// Contents:
//   DebounceCyclesDefault - default number of consecutive stable cycles before a
//                           debounced level is accepted.
//   cnt_width()           - width of a debounce counter able to hold DEBOUNCE_CYCLES,
//                           so board top-levels and benches size counters identically.
package mux_input_conditioner_pkg;

  localparam int unsigned DebounceCyclesDefault = 1000;

  // clog2(cycles + 1): the counter only ever reaches cycles - 1, but sizing for
  // cycles + 1 keeps the width at least 1 bit for the cycles == 1 corner.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return unsigned'($clog2(cycles + 1));
  endfunction

endpackage

// File: rtl/mux_input_conditioner_debounce_cell.sv
// Single-input synchroniser and debouncer.
//
// Ports:
//   clk     - system clock, all state updates on the rising edge
//   rst     - synchronous active-high reset
//   din_raw - asynchronous raw switch/button level
//   dout    - debounced, registered level (the stable register)
//
// din_raw passes through a 2-flop synchroniser. The stable register only takes
// the synchronised value after it has differed from stable for DEBOUNCE_CYCLES
// consecutive edges; any return to the stable value clears the count.
module debounce_cell
  import mux_input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault
) (
  input  logic clk,
  input  logic rst,
  input  logic din_raw,
  output logic dout
);

  localparam int unsigned    CntW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            stable_q, stable_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = din_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CntMax) begin
        // Enough consecutive differing edges: accept the new level.
        stable_d = sync2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout = stable_q;

endmodule

// File: rtl/mux_input_conditioner.sv
// Input conditioner for a 2-to-1 mux stage: synchronises and debounces the data
// switches a/b and the select input s, and optionally turns the select button
// into a latched toggle.
//
// Ports:
//   clk     - system clock
//   rst     - synchronous active-high reset
//   a_raw   - raw switch level for mux data input a
//   b_raw   - raw switch level for mux data input b
//   s_raw   - raw select switch or push-button level
//   a       - debounced a_raw
//   b       - debounced b_raw
//   s       - mux select: toggled per debounced press (SEL_TOGGLE=1) or the
//             debounced s_raw level (SEL_TOGGLE=0)
//   s_pulse - one-cycle strobe per debounced rising edge of s_raw
module mux_input_conditioner
  import mux_input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault,
  parameter int unsigned SEL_TOGGLE      = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic a_raw,
  input  logic b_raw,
  input  logic s_raw,
  output logic a,
  output logic b,
  output logic s,
  output logic s_pulse
);

  logic s_stable;
  logic s_rise;
  logic s_prev_q, s_prev_d;
  logic s_pulse_q, s_pulse_d;
  logic s_tog_q, s_tog_d;

  debounce_cell #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_a (
    .clk    (clk),
    .rst    (rst),
    .din_raw(a_raw),
    .dout   (a)
  );

  debounce_cell #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_b (
    .clk    (clk),
    .rst    (rst),
    .din_raw(b_raw),
    .dout   (b)
  );

  debounce_cell #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_s (
    .clk    (clk),
    .rst    (rst),
    .din_raw(s_raw),
    .dout   (s_stable)
  );

  // s_prev_q lags the stable select by one edge, so s_rise is high for the
  // cycle right after the debounced level went 0 -> 1.
  always_comb begin
    s_rise    = s_stable & ~s_prev_q;
    s_prev_d  = s_stable;
    s_pulse_d = s_rise;
    s_tog_d   = s_tog_q ^ s_rise;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_prev_q  <= 1'b0;
      s_pulse_q <= 1'b0;
      s_tog_q   <= 1'b0;
    end else begin
      s_prev_q  <= s_prev_d;
      s_pulse_q <= s_pulse_d;
      s_tog_q   <= s_tog_d;
    end
  end

  // Both sources are flop outputs, so s stays a glitch-free registered level.
  assign s       = (SEL_TOGGLE != 0) ? s_tog_q : s_stable;
  assign s_pulse = s_pulse_q;

endmodule

// File: tb/tb_mux_input_conditioner.sv
// Bench for mux_input_conditioner with DEBOUNCE_CYCLES = 4. One instance runs in
// toggle mode, one in level mode, both fed the same raw inputs. A reference
// model predicts every cycle's outputs into a scoreboard queue; directed checks
// cover latency, glitch rejection, toggle sequence and strobe counts.
module tb_mux_input_conditioner;

  localparam int N = 4;

  logic clk;
  logic rst;
  logic a_raw, b_raw, s_raw;
  logic a_t, b_t, s_t, p_t;
  logic a_l, b_l, s_l, p_l;

  mux_input_conditioner #(
    .DEBOUNCE_CYCLES(N),
    .SEL_TOGGLE     (1)
  ) dut_tog (
    .clk    (clk),
    .rst    (rst),
    .a_raw  (a_raw),
    .b_raw  (b_raw),
    .s_raw  (s_raw),
    .a      (a_t),
    .b      (b_t),
    .s      (s_t),
    .s_pulse(p_t)
  );

  mux_input_conditioner #(
    .DEBOUNCE_CYCLES(N),
    .SEL_TOGGLE     (0)
  ) dut_lvl (
    .clk    (clk),
    .rst    (rst),
    .a_raw  (a_raw),
    .b_raw  (b_raw),
    .s_raw  (s_raw),
    .a      (a_l),
    .b      (b_l),
    .s      (s_l),
    .s_pulse(p_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_err = 0;
  string phase = "init";

  // Reference model state; bit 0 = a, bit 1 = b, bit 2 = s.
  logic [2:0] m_sync1 = '0;
  logic [2:0] m_sync2 = '0;
  logic [2:0] m_st    = '0;
  logic       m_prev  = 1'b0;
  logic       m_pulse = 1'b0;
  logic       m_tog   = 1'b0;
  logic [2:0] hist_q[$];
  logic [5:0] exp_q[$];

  int pulse_cnt_t = 0;
  int pulse_cnt_l = 0;
  int b_high_cnt  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Level accepted once the synchronised input differed from it on the last N edges.
  task automatic model_edge();
    logic       rise;
    logic       all_diff;
    logic [2:0] dropped;
    if (rst) begin
      m_sync1 = '0;
      m_sync2 = '0;
      m_st    = '0;
      m_prev  = 1'b0;
      m_pulse = 1'b0;
      m_tog   = 1'b0;
      hist_q.delete();
    end else begin
      rise    = m_st[2] & ~m_prev;
      m_pulse = rise;
      m_tog   = m_tog ^ rise;
      m_prev  = m_st[2];
      hist_q.push_back(m_sync2);
      if (hist_q.size() > N) dropped = hist_q.pop_front();
      if (hist_q.size() == N) begin
        for (int ch = 0; ch < 3; ch++) begin
          all_diff = 1'b1;
          for (int k = 0; k < N; k++) begin
            if (hist_q[k][ch] == m_st[ch]) all_diff = 1'b0;
          end
          if (all_diff) m_st[ch] = ~m_st[ch];
        end
      end
      m_sync2 = m_sync1;
      m_sync1 = {s_raw, b_raw, a_raw};
    end
    exp_q.push_back({m_st[0], m_st[1], m_tog, m_pulse, m_st[2], m_pulse});
  endtask

  task automatic tick();
    logic [5:0] e;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    e = exp_q.pop_front();
    check_val(phase, {a_t, b_t, s_t, p_t, s_l, p_l}, e);
    if (p_t) pulse_cnt_t++;
    if (p_l) pulse_cnt_l++;
    if (b_t) b_high_cnt++;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) tick();
    rst = 1'b0;
  endtask

  // Ticks until the selected output (0 = a, 1 = b) is high; returns -1 on timeout.
  task automatic wait_rise(input int which, output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if ((which == 0) ? a_t : b_t) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    rst   = 1'b1;
    a_raw = 1'b0;
    b_raw = 1'b0;
    s_raw = 1'b0;

    // Reset held with all raw inputs high; outputs must stay 0.
    phase = "reset_hold";
    a_raw = 1'b1;
    b_raw = 1'b1;
    s_raw = 1'b1;
    do_reset(3);
    phase = "reset_release";
    wait_rise(0, n);
    check_val("reset_a_latency", n, 6);
    a_raw = 1'b0;
    b_raw = 1'b0;
    s_raw = 1'b0;
    repeat (12) tick();

    // Clean step on a; b and s untouched.
    phase = "clean_step";
    do_reset(2);
    a_raw = 1'b1;
    wait_rise(0, n);
    check_val("step_a_latency", n, 6);
    check_val("step_b_quiet", b_t, 0);
    check_val("step_s_quiet", s_t, 0);
    repeat (8) tick();

    // Short glitch on b must be rejected.
    phase = "glitch_short";
    b_high_cnt = 0;
    b_raw = 1'b1;
    repeat (3) tick();
    b_raw = 1'b0;
    repeat (10) tick();
    check_val("glitch_b_never_high", b_high_cnt, 0);

    // high 3, low 1, then held high: only the final run counts.
    phase = "glitch_restart";
    b_raw = 1'b1;
    repeat (3) tick();
    b_raw = 1'b0;
    tick();
    b_raw = 1'b1;
    wait_rise(1, n);
    check_val("glitch_b_latency", n, 6);
    b_raw = 1'b0;
    a_raw = 1'b0;
    repeat (10) tick();

    // Three presses in toggle mode: s goes 1, 0, 1; releases do nothing.
    phase = "toggle";
    do_reset(2);
    pulse_cnt_t = 0;
    pulse_cnt_l = 0;
    for (int p = 0; p < 3; p++) begin
      s_raw = 1'b1;
      repeat (10) tick();
      check_val($sformatf("toggle_s_press%0d", p), s_t, (p % 2 == 0) ? 1 : 0);
      s_raw = 1'b0;
      repeat (10) tick();
      check_val($sformatf("toggle_s_release%0d", p), s_t, (p % 2 == 0) ? 1 : 0);
    end
    check_val("toggle_pulse_count", pulse_cnt_t, 3);
    check_val("toggle_lvl_pulse_count", pulse_cnt_l, 3);

    // Level mode follows the debounced level; one strobe on the rise only.
    phase = "level";
    do_reset(2);
    pulse_cnt_l = 0;
    s_raw = 1'b1;
    repeat (10) tick();
    check_val("level_s_high", s_l, 1);
    s_raw = 1'b0;
    repeat (10) tick();
    check_val("level_s_low", s_l, 0);
    check_val("level_pulse_count", pulse_cnt_l, 1);

    // Reset on the third counting edge discards the count.
    phase = "reset_mid";
    do_reset(2);
    a_raw = 1'b1;
    repeat (4) tick();
    check_val("reset_mid_a_low", a_t, 0);
    do_reset(1);
    phase = "reset_mid_after";
    wait_rise(0, n);
    check_val("reset_mid_a_latency", n, 6);
    a_raw = 1'b0;
    repeat (8) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux_input_conditioner.md
# mux_input_conditioner

Conditions the raw slide-switch and push-button inputs that feed the 2-to-1 multiplexer stage (`a`, `b`, select `s`). Each input is synchronised into the `clk` domain and debounced; the select can optionally be converted from a momentary push-button into a latched toggle. Outputs connect directly to the mux data and select inputs and are glitch-free registered levels.

## Interface
- `DEBOUNCE_CYCLES`, default 1000: consecutive stable cycles required before a debounced output changes. Legal range is 1 or more.
- `SEL_TOGGLE`, default 1: select mode. 1 means each debounced press of `s_raw` flips `s`. 0 means `s` follows the debounced `s_raw` level.
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `a_raw`  in  1  asynchronous switch level for mux data input a.
- `b_raw`  in  1  asynchronous switch level for mux data input b.
- `s_raw`  in  1  asynchronous select switch or button level.
- `a`  out  1  debounced `a_raw`, to the mux `a` input.
- `b`  out  1  debounced `b_raw`, to the mux `b` input.
- `s`  out  1  select to the mux, either toggled or level per `SEL_TOGGLE`.
- `s_pulse`  out  1  one-cycle strobe on each debounced rising edge of `s_raw`.

## Operation
- Each of the three inputs has its own channel. A channel contains:
  - a 2-flop synchroniser (`sync1` then `sync2`);
  - a stable register;
  - a counter.
- Counter behaviour:
  - When `sync2` equals stable, counter := 0.
  - When `sync2` differs from stable, counter increments.
  - On the edge where counter = `DEBOUNCE_CYCLES`-1 and `sync2` still differs: stable := `sync2` and counter := 0.
- Glitch rejection: if `sync2` returns to the stable value at any point before the flip, the counter clears. A partial count is never retained.
- Counter width is clog2(`DEBOUNCE_CYCLES`+1). The counter never exceeds `DEBOUNCE_CYCLES`-1 and never wraps.
- `a` = stable(a), `b` = stable(b).
- Rise detection: `s_rise` = stable(s) rose on this edge, i.e. new stable = 1 and previous stable = 0.
- `s_pulse` is a registered `s_rise`.
- `SEL_TOGGLE`=1: `s` flips on the same edge that registers `s_pulse`=1. A debounced release (1 to 0) has no effect on `s`.
- `SEL_TOGGLE`=0: `s` = stable(s). `s_pulse` still operates.
- Channels are fully independent. Simultaneous changes on all three inputs resolve on the same edge.

## Timing
- Reset values: all sync flops, stable registers, counters, `a`, `b`, `s` and `s_pulse` are 0. Reset is checked before any other update.
- Reset asserted mid-debounce discards the in-progress count. After `rst` falls, a held-high raw input requires the full latency again.
- Latency: let raw be first sampled at its new level on edge 0 (`sync1`). Then:
  - `sync2` updates on edge 1;
  - counting runs over edges 2..`DEBOUNCE_CYCLES`+1;
  - `a`/`b`/stable(s) change on edge `DEBOUNCE_CYCLES`+1.
- `s_pulse` is high for exactly the cycle after edge `DEBOUNCE_CYCLES`+2.
- In toggle mode, `s` changes on that same edge (`DEBOUNCE_CYCLES`+2).
- Boundary case, `DEBOUNCE_CYCLES`=1: the output follows `sync2` with one cycle of extra delay. No filtering of single-cycle glitches is required in this case.
- A glitch of `DEBOUNCE_CYCLES`-1 cycles or fewer, measured at `sync2`, must never reach any output.

## Structure
- Shared header/package:
  - the `DEBOUNCE_CYCLES` default constant;
  - the counter-width computation (clog2 helper), so board top-levels and the bench agree.
- Sub-module `debounce_cell`:
  - ports `clk`, `rst`, `din_raw`, `dout`, with parameter `DEBOUNCE_CYCLES`;
  - contains the synchroniser, counter and stable register;
  - instantiated three times.
- Top level adds the `s` edge detector, the `s_pulse` register and the toggle flop selected by `SEL_TOGGLE`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- Reset: hold `rst`=1 for 3 cycles with all raw inputs = 1. Required: `a`=`b`=`s`=`s_pulse`=0 throughout. After release, `a` rises exactly 5 edges after the first post-reset sampling edge.
- Clean step: `a_raw` goes 0 to 1 and holds. Required: `a`=1 after edge 5 counted from the sampling edge, i.e. 5 cycles later, and `b`/`s` unchanged.
- Glitch rejection:
  - `b_raw` high for 3 cycles, then low: `b` stays 0.
  - `b_raw` pulses high 3, low 1, high 5: `b` rises only after the final 4-cycle stable run completes.
- Toggle mode (`SEL_TOGGLE`=1): three clean presses of `s_raw`, each held high 10 cycles then low 10. Required: `s` sequence 1, 0, 1; exactly three single-cycle `s_pulse` strobes; no change on releases.
- Level mode (`SEL_TOGGLE`=0): `s_raw` held high 10 cycles then low. Required: `s` mirrors the debounced level; one `s_pulse` on the rise only.
- Reset mid-debounce: `a_raw`=1 and `rst` pulsed on the 3rd counting cycle. Required: `a` stays 0 and rises only after a fresh 5-edge latency following reset release.
